hazard_controller: RTL and testbench
====================================

HAZARD_CONTROLLER -- requirements
Module: hazard_controller

Interface
REQ-001 Parameter MD_CYCLES, default 32, multi-cycle mul/div latency in cycles; legal range 2..255.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset; synchronous, active-low.
REQ-004 RsD, RtD  input  5 each  source registers of the instruction in Decode.
REQ-005 RsE, RtE  input  5 each  source registers of the instruction in Execute.
REQ-006 WriteRegE, WriteRegM, WriteRegW  input  5 each  destination registers in E/M/W.
REQ-007 RegWriteE, RegWriteM, RegWriteW  input  1 each  register-write enables in E/M/W.
REQ-008 MemtoRegE, MemtoRegM  input  1 each  load-in-stage flags.
REQ-009 BranchD  input  1  branch resolving in Decode.
REQ-010 MulDivStartE  input  1  multi-cycle mul/div issued from Execute this cycle.
REQ-011 ForwardAE, ForwardBE  output  2 each  Execute operand select: 00 register file, 01 ResultW, 10 ALUOutM.
REQ-012 ForwardAD, ForwardBD  output  1 each  Decode comparator select ALUOutM.
REQ-013 StallF, StallD, FlushE  output  1 each  pipeline hold/bubble controls.
REQ-014 MdBusy  output  1  mul/div unit occupied.
REQ-015 MdDone  output  1  one-cycle pulse on final busy cycle.

Function
REQ-016 ForwardAE SHALL be 10 when RsE!=0, RsE==WriteRegM, RegWriteM; else 01 when RsE!=0, RsE==WriteRegW, RegWriteW; else 00 (M beats W).
REQ-017 ForwardBE SHALL follow REQ-016 with RtE in place of RsE.
REQ-018 ForwardAD SHALL be 1 iff RsD!=0, RsD==WriteRegM, RegWriteM; ForwardBD likewise with RtD.
REQ-019 lwstall SHALL be MemtoRegE and RtE!=0 and (RtE==RsD or RtE==RtD).
REQ-020 branchstall SHALL be BranchD and ((RegWriteE, WriteRegE!=0, WriteRegE in {RsD,RtD}) or (MemtoRegM, WriteRegM!=0, WriteRegM in {RsD,RtD})).
REQ-021 FSM states IDLE, BUSY; 8-bit down-counter cnt.
REQ-022 IDLE with MulDivStartE=1 SHALL enter BUSY, cnt=MD_CYCLES-1; otherwise stay IDLE.
REQ-023 BUSY SHALL decrement cnt each cycle; when cnt==1, MdDone=1 that cycle and next state IDLE.
REQ-024 MulDivStartE in BUSY SHALL be ignored (no restart, no count change).
REQ-025 MdBusy SHALL equal (state==BUSY); BUSY lasts exactly MD_CYCLES-1 cycles.
REQ-026 StallF=StallD SHALL equal lwstall|branchstall|MdBusy; FlushE SHALL equal the same OR.
REQ-027 Forwarding, stall and flush outputs SHALL be combinational (zero latency); only FSM/counter are registered.
REQ-028 Simultaneous lwstall/branchstall and MdBusy SHALL yield a single stall, no extra cycles.

Reset
REQ-029 rst_n=0 at a clock edge SHALL force IDLE, cnt=0, MdBusy=0, MdDone=0, regardless of MulDivStartE.
REQ-030 Reset mid-BUSY SHALL abort the operation; no MdDone pulse is produced.
REQ-031 Combinational outputs SHALL track inputs during reset with the MdBusy term at 0.

Configuration
REQ-032 Macro HAZARD_STALL_CNT_EN defined: output StallCount (32) SHALL increment each cycle StallD=1, wrap 0xFFFFFFFF->0, and clear on reset.
REQ-033 Macro undefined: StallCount port and counter SHALL be absent; all other behaviour identical.

Verification
REQ-034 RsE=4, WriteRegM=4, RegWriteM=1, WriteRegW=4, RegWriteW=1 -> ForwardAE=10; drop RegWriteM -> 01; RsE=0 -> 00.
REQ-035 MemtoRegE=1, RtE=5, RsD=5 -> StallF=StallD=FlushE=1 same cycle; RtE=0 -> all 0.
REQ-036 BranchD=1, RegWriteE=1, WriteRegE=6, RtD=6 -> stall; next cycle WriteRegM=6, RegWriteM=1, MemtoRegM=0 -> no stall, ForwardBD=1.
REQ-037 MD_CYCLES=4, MulDivStartE pulse at edge N -> MdBusy=1 cycles N+1..N+3, MdDone in N+3, stall 3 cycles; restart pulse at N+2 ignored.
REQ-038 MulDivStartE at edge N, rst_n=0 at N+2 -> IDLE after N+2, MdBusy=0, no MdDone; with HAZARD_STALL_CNT_EN StallCount=0 after reset.

Source files
------------

// File: rtl/hazard_controller.sv
// Pipeline hazard unit: forwarding selects, load/branch/mul-div stalls and a multi-cycle mul/div busy tracker.
// Optional macro HAZARD_STALL_CNT_EN adds a 32-bit StallCount output.
module hazard_controller #(
   parameter int unsigned MD_CYCLES = 32
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [4:0] RsD,
   input  logic [4:0] RtD,
   input  logic [4:0] RsE,
   input  logic [4:0] RtE,
   input  logic [4:0] WriteRegE,
   input  logic [4:0] WriteRegM,
   input  logic [4:0] WriteRegW,
   input  logic       RegWriteE,
   input  logic       RegWriteM,
   input  logic       RegWriteW,
   input  logic       MemtoRegE,
   input  logic       MemtoRegM,
   input  logic       BranchD,
   input  logic       MulDivStartE,
   output logic [1:0] ForwardAE,
   output logic [1:0] ForwardBE,
   output logic       ForwardAD,
   output logic       ForwardBD,
   output logic       StallF,
   output logic       StallD,
   output logic       FlushE,
   output logic       MdBusy,
   output logic       MdDone
`ifdef HAZARD_STALL_CNT_EN
   ,
   output logic [31:0] StallCount
`endif
);

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } state_t;

   localparam logic [7:0] LP_CNT_INIT = 8'(MD_CYCLES - 1);

   state_t     r_state;
   state_t     w_state_nxt;
   logic [7:0] r_cnt;
   logic [7:0] w_cnt_nxt;
   logic       w_md_done;
   logic       w_lwstall;
   logic       w_branchstall;
   logic       w_stall;

   // Execute operand forwarding: the younger M result wins over W.
   always_comb begin
      ForwardAE = 2'b00;
      ForwardBE = 2'b00;
      if ((RsE != 5'd0) && RegWriteM && (RsE == WriteRegM))
         ForwardAE = 2'b10;
      else if ((RsE != 5'd0) && RegWriteW && (RsE == WriteRegW))
         ForwardAE = 2'b01;
      if ((RtE != 5'd0) && RegWriteM && (RtE == WriteRegM))
         ForwardBE = 2'b10;
      else if ((RtE != 5'd0) && RegWriteW && (RtE == WriteRegW))
         ForwardBE = 2'b01;
   end

   assign ForwardAD = (RsD != 5'd0) && RegWriteM && (RsD == WriteRegM);
   assign ForwardBD = (RtD != 5'd0) && RegWriteM && (RtD == WriteRegM);

   assign w_lwstall = MemtoRegE && (RtE != 5'd0) && ((RtE == RsD) || (RtE == RtD));

   // A branch compares in Decode, so it must wait for an E-stage ALU result or an M-stage load.
   assign w_branchstall = BranchD &&
      ((RegWriteE && (WriteRegE != 5'd0) && ((WriteRegE == RsD) || (WriteRegE == RtD))) ||
       (MemtoRegM && (WriteRegM != 5'd0) && ((WriteRegM == RsD) || (WriteRegM == RtD))));

   assign MdBusy  = (r_state == ST_BUSY);
   assign MdDone  = w_md_done;
   assign w_stall = w_lwstall || w_branchstall || MdBusy;
   assign StallF  = w_stall;
   assign StallD  = w_stall;
   assign FlushE  = w_stall;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_cnt   <= 8'd0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   // Start requests are only honoured from IDLE; the busy window is MD_CYCLES-1 cycles.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_md_done   = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (MulDivStartE) begin
               w_state_nxt = ST_BUSY;
               w_cnt_nxt   = LP_CNT_INIT;
            end
         end
         ST_BUSY: begin
            w_cnt_nxt = r_cnt - 8'd1;
            if (r_cnt == 8'd1) begin
               w_md_done   = 1'b1;
               w_state_nxt = ST_IDLE;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = 8'd0;
         end
      endcase
   end

`ifdef HAZARD_STALL_CNT_EN
   logic [31:0] r_stall_count;

   always_ff @(posedge clk) begin
      if (!rst_n)
         r_stall_count <= 32'd0;
      else if (w_stall)
         r_stall_count <= r_stall_count + 32'd1;
   end

   assign StallCount = r_stall_count;
`endif

endmodule

// File: tb/tb_hazard_controller.sv
// Bench for hazard_controller: rule-level model checked every cycle plus hand-computed directed checks.
// Also exercises StallCount when HAZARD_STALL_CNT_EN is defined.
module tb_hazard_controller;

   localparam int MD = 4;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [4:0] RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW;
   logic       RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM, BranchD, MulDivStartE;
   logic [1:0] ForwardAE, ForwardBE;
   logic       ForwardAD, ForwardBD, StallF, StallD, FlushE, MdBusy, MdDone;
`ifdef HAZARD_STALL_CNT_EN
   logic [31:0] StallCount;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   hazard_controller #(.MD_CYCLES(MD)) dut (
      .clk(clk), .rst_n(rst_n),
      .RsD(RsD), .RtD(RtD), .RsE(RsE), .RtE(RtE),
      .WriteRegE(WriteRegE), .WriteRegM(WriteRegM), .WriteRegW(WriteRegW),
      .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
      .MemtoRegE(MemtoRegE), .MemtoRegM(MemtoRegM), .BranchD(BranchD),
      .MulDivStartE(MulDivStartE),
      .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .ForwardAD(ForwardAD), .ForwardBD(ForwardBD),
      .StallF(StallF), .StallD(StallD), .FlushE(FlushE), .MdBusy(MdBusy), .MdDone(MdDone)
`ifdef HAZARD_STALL_CNT_EN
      , .StallCount(StallCount)
`endif
   );

   // clock / reset
   always #5 clk = ~clk;

   // ---------------- model ----------------
   int          edge_cnt  = 0;
   int          md_start  = -1000;
   bit          chk_en    = 1'b0;
   logic [31:0] m_stall_cnt = 32'd0;

   function automatic logic [1:0] m_fwd_e(input logic [4:0] src);
      if (src != 0 && RegWriteM && src == WriteRegM) return 2'b10;
      if (src != 0 && RegWriteW && src == WriteRegW) return 2'b01;
      return 2'b00;
   endfunction

   function automatic logic m_fwd_d(input logic [4:0] src);
      return (src != 0 && RegWriteM && src == WriteRegM);
   endfunction

   // busy after edge e iff the operation was accepted at an edge s with 0 <= e-s <= MD-2
   function automatic logic m_busy(input int e);
      return (e - md_start >= 0) && (e - md_start <= MD - 2);
   endfunction

   function automatic logic m_done(input int e);
      return (e - md_start == MD - 2);
   endfunction

   function automatic logic m_stall(input logic busy);
      logic lw, br;
      lw = MemtoRegE && RtE != 0 && (RtE == RsD || RtE == RtD);
      br = BranchD && ((RegWriteE && WriteRegE != 0 && (WriteRegE == RsD || WriteRegE == RtD)) ||
                       (MemtoRegM && WriteRegM != 0 && (WriteRegM == RsD || WriteRegM == RtD)));
      return lw || br || busy;
   endfunction

   always @(posedge clk) begin
      logic prev_busy, stall_pre;
      prev_busy = m_busy(edge_cnt);
      stall_pre = m_stall(prev_busy);
      edge_cnt  = edge_cnt + 1;
      if (!rst_n) begin
         md_start    = -1000;
         m_stall_cnt = 32'd0;
         chk_en      = 1'b1;
      end else begin
         if (!prev_busy && MulDivStartE) md_start = edge_cnt;
         if (stall_pre) m_stall_cnt = m_stall_cnt + 32'd1;
      end
   end

   // ---------------- scoreboard ----------------
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s t=%0t actual=%0h expected=%0h", name, $time, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         logic busy, stall;
         busy  = m_busy(edge_cnt);
         stall = m_stall(busy);
         check("cmp_fwd_ae", 32'(ForwardAE), 32'(m_fwd_e(RsE)));
         check("cmp_fwd_be", 32'(ForwardBE), 32'(m_fwd_e(RtE)));
         check("cmp_fwd_ad", 32'(ForwardAD), 32'(m_fwd_d(RsD)));
         check("cmp_fwd_bd", 32'(ForwardBD), 32'(m_fwd_d(RtD)));
         check("cmp_md_busy", 32'(MdBusy), 32'(busy));
         check("cmp_md_done", 32'(MdDone), 32'(m_done(edge_cnt)));
         check("cmp_stall_f", 32'(StallF), 32'(stall));
         check("cmp_stall_d", 32'(StallD), 32'(stall));
         check("cmp_flush_e", 32'(FlushE), 32'(stall));
`ifdef HAZARD_STALL_CNT_EN
         check("cmp_stall_count", StallCount, m_stall_cnt);
`endif
      end
   end

   // ---------------- driver tasks ----------------
   task automatic clear_inputs();
      RsD = 0; RtD = 0; RsE = 0; RtE = 0;
      WriteRegE = 0; WriteRegM = 0; WriteRegW = 0;
      RegWriteE = 0; RegWriteM = 0; RegWriteW = 0;
      MemtoRegE = 0; MemtoRegM = 0; BranchD = 0; MulDivStartE = 0;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   initial begin
      clear_inputs();
      rst_n = 1'b0;
      MulDivStartE = 1'b1;  // must be ignored under reset
      step();
      step();
      settle();
      check("rst_md_busy", 32'(MdBusy), 32'd0);
      check("rst_md_done", 32'(MdDone), 32'd0);
      check("rst_stall", 32'(StallD), 32'd0);
      MulDivStartE = 1'b0;
      rst_n = 1'b1;
      step();

      // Execute forwarding priority
      RsE = 4; WriteRegM = 4; RegWriteM = 1; WriteRegW = 4; RegWriteW = 1;
      settle();
      check("fwd_ae_m", 32'(ForwardAE), 32'd2);
      RegWriteM = 0; settle();
      check("fwd_ae_w", 32'(ForwardAE), 32'd1);
      RsE = 0; settle();
      check("fwd_ae_zero", 32'(ForwardAE), 32'd0);
      RtE = 9; WriteRegM = 9; RegWriteM = 1; WriteRegW = 9; settle();
      check("fwd_be_m", 32'(ForwardBE), 32'd2);
      step();
      clear_inputs();

      // load-use stall
      MemtoRegE = 1; RtE = 5; RsD = 5; settle();
      check("lw_stall_f", 32'(StallF), 32'd1);
      check("lw_flush_e", 32'(FlushE), 32'd1);
      RtE = 0; RsD = 0; settle();
      check("lw_rt0", 32'(StallD), 32'd0);
      step();
      clear_inputs();

      // branch hazard on E result, then resolved by forwarding from M
      BranchD = 1; RegWriteE = 1; WriteRegE = 6; RtD = 6; settle();
      check("br_stall_e", 32'(StallD), 32'd1);
      step();
      RegWriteE = 0; WriteRegE = 0; WriteRegM = 6; RegWriteM = 1; MemtoRegM = 0; settle();
      check("br_nostall_m", 32'(StallD), 32'd0);
      check("br_fwd_bd", 32'(ForwardBD), 32'd1);
      MemtoRegM = 1; settle();
      check("br_stall_load_m", 32'(StallD), 32'd1);
      step();
      clear_inputs();
      step();

      // mul/div: start sampled at edge N, restart at N+2 ignored
      MulDivStartE = 1;
      step();                        // edge N
      MulDivStartE = 0; settle();
      check("md_busy_n1", 32'(MdBusy), 32'd1);
      check("md_done_n1", 32'(MdDone), 32'd0);
      check("md_stall_n1", 32'(StallF), 32'd1);
      step();                        // edge N+1
      MulDivStartE = 1; settle();
      check("md_busy_n2", 32'(MdBusy), 32'd1);
      check("md_done_n2", 32'(MdDone), 32'd0);
      step();                        // edge N+2
      MulDivStartE = 0; settle();
      check("md_busy_n3", 32'(MdBusy), 32'd1);
      check("md_done_n3", 32'(MdDone), 32'd1);
      step();                        // edge N+3
      settle();
      check("md_busy_after", 32'(MdBusy), 32'd0);
      check("md_stall_after", 32'(StallD), 32'd0);
      step();
      settle();
      check("md_no_restart", 32'(MdBusy), 32'd0);

      // reset during busy aborts without MdDone
      MulDivStartE = 1;
      step();
      MulDivStartE = 0;
      step();
      settle();
      check("md_abort_pre", 32'(MdBusy), 32'd1);
      rst_n = 0;
      step();
      settle();
      check("md_abort_busy", 32'(MdBusy), 32'd0);
      check("md_abort_done", 32'(MdDone), 32'd0);
`ifdef HAZARD_STALL_CNT_EN
      check("stall_cnt_rst", StallCount, 32'd0);
`endif
      RsE = 3; WriteRegM = 3; RegWriteM = 1; settle();
      check("rst_fwd_track", 32'(ForwardAE), 32'd2);
      rst_n = 1;
      step();
      clear_inputs();

      // mixed stimulus, checked by the model every cycle
      for (int i = 0; i < 300; i++) begin
         RsD = 5'($urandom_range(0, 3)); RtD = 5'($urandom_range(0, 3));
         RsE = 5'($urandom_range(0, 3)); RtE = 5'($urandom_range(0, 3));
         WriteRegE = 5'($urandom_range(0, 3));
         WriteRegM = 5'($urandom_range(0, 3));
         WriteRegW = 5'($urandom_range(0, 3));
         RegWriteE = 1'($urandom_range(0, 1)); RegWriteM = 1'($urandom_range(0, 1));
         RegWriteW = 1'($urandom_range(0, 1)); MemtoRegE = 1'($urandom_range(0, 1));
         MemtoRegM = 1'($urandom_range(0, 1)); BranchD = 1'($urandom_range(0, 1));
         MulDivStartE = ($urandom_range(0, 5) == 0);
         rst_n = ($urandom_range(0, 40) != 0);
         step();
      end
      rst_n = 1;
      clear_inputs();
      step();
      step();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
